// File: rtl/game_pkg.sv
// Shared definitions for the game-object controllers: screen geometry,
// coordinate width, the enemy-bullet FSM state type and counter sizing.
package game_pkg;

    localparam int unsigned SCREEN_W     = 640;
    localparam int unsigned SCREEN_H     = 480;
    localparam int unsigned COORD_W      = 10;
    // One extra bit so coordinate sums never wrap.
    localparam int unsigned SUM_W        = COORD_W + 1;
    localparam int unsigned MOVE_DIV_DEF = 150_000;

    // Width of a counter that must hold 0..n-1 (at least one bit).
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned TICK_W = cnt_w(MOVE_DIV_DEF);

    typedef enum logic [1:0] {
        IDLE,
        COOL,
        FLY
    } eb_state_e;

endpackage

// File: rtl/enemy_bullet_ctrl_if.sv
// Signal bundle between the enemy plane / hit judge and the enemy bullet
// controller.
//   enemy_en, e_x, e_y, pause, hit : into the controller
//   eb_x, eb_y, eb_en, fire        : out of the controller
// master = the bullet controller, slave = its environment.
interface enemy_bullet_ctrl_if;
    import game_pkg::*;

    logic               enemy_en;
    logic [COORD_W-1:0] e_x;
    logic [COORD_W-1:0] e_y;
    logic               pause;
    logic               hit;
    logic [COORD_W-1:0] eb_x;
    logic [COORD_W-1:0] eb_y;
    logic               eb_en;
    logic               fire;

    modport master (
        input  enemy_en, e_x, e_y, pause, hit,
        output eb_x, eb_y, eb_en, fire
    );

    modport slave (
        output enemy_en, e_x, e_y, pause, hit,
        input  eb_x, eb_y, eb_en, fire
    );

endinterface

// File: rtl/tick_gen.sv
// Movement tick generator: free-running counter 0..DIV-1 producing a
// one-cycle strobe on the last count. en=0 freezes the count and gates tick.
//   clk, rst_n : clock, async active-low reset
//   en         : count enable
//   tick       : 1-cycle strobe every DIV enabled cycles
module tick_gen
    import game_pkg::*;
#(
    parameter int unsigned DIV = MOVE_DIV_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int unsigned   CW   = cnt_w(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (en) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/enemy_bullet_ctrl.sv
// Enemy bullet controller: spawns one bullet at the enemy muzzle after a
// cool-down of FIRE_GAP ticks, moves it down by STEP per tick, and retires it
// on a hit from the judge or when it would leave the screen.
//   clk, rst_n : clock, async active-low reset
//   bus        : enemy_en/e_x/e_y/pause/hit in, eb_x/eb_y/eb_en/fire out
module enemy_bullet_ctrl
    import game_pkg::*;
#(
    parameter int unsigned MOVE_DIV = MOVE_DIV_DEF,
    parameter int unsigned STEP     = 4,
    parameter int unsigned FIRE_GAP = 40,
    parameter int unsigned MUZZLE_X = 20,
    parameter int unsigned MUZZLE_Y = 40,
    parameter int unsigned X_MAX    = SCREEN_W,
    parameter int unsigned Y_LIMIT  = SCREEN_H
) (
    input  logic                clk,
    input  logic                rst_n,
    enemy_bullet_ctrl_if.master bus
);

    localparam int unsigned        CCW       = cnt_w(FIRE_GAP);
    localparam logic [CCW-1:0]     COOL_LAST = CCW'(FIRE_GAP - 1);
    localparam logic [SUM_W-1:0]   STEP_S    = SUM_W'(STEP);
    localparam logic [SUM_W-1:0]   MZX_S     = SUM_W'(MUZZLE_X);
    localparam logic [SUM_W-1:0]   MZY_S     = SUM_W'(MUZZLE_Y);
    localparam logic [SUM_W-1:0]   XMAX_S    = SUM_W'(X_MAX);
    localparam logic [SUM_W-1:0]   YLIM_S    = SUM_W'(Y_LIMIT);
    localparam logic [COORD_W-1:0] X_LAST    = COORD_W'(X_MAX - 1);

    eb_state_e          state_q, state_d;
    logic [CCW-1:0]     cool_q, cool_d;
    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic               en_q, en_d;
    logic               fire_q, fire_d;

    logic               tick;
    logic               move_en;
    logic [SUM_W-1:0]   spawn_x, spawn_y, step_y;
    logic [COORD_W-1:0] clip_x;
    logic               spawn_ok, off_screen, gap_done, retire;

    assign move_en = ~bus.pause;

    tick_gen #(.DIV(MOVE_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (move_en),
        .tick  (tick)
    );

    // All sums are one bit wider than a coordinate so nothing wraps.
    assign spawn_x    = {1'b0, bus.e_x} + MZX_S;
    assign spawn_y    = {1'b0, bus.e_y} + MZY_S;
    assign step_y     = {1'b0, y_q} + STEP_S;
    assign clip_x     = (spawn_x >= XMAX_S) ? X_LAST : spawn_x[COORD_W-1:0];
    assign spawn_ok   = (spawn_y < YLIM_S);
    assign off_screen = (step_y >= YLIM_S);
    assign gap_done   = tick && (cool_q == COOL_LAST);
    // hit wins over a coincident tick; either way the bullet is gone.
    assign retire     = bus.hit || (tick && off_screen);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cool_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            en_q    <= 1'b0;
            fire_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cool_q  <= cool_d;
            x_q     <= x_d;
            y_q     <= y_d;
            en_q    <= en_d;
            fire_q  <= fire_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.enemy_en) state_d = COOL;
            COOL: begin
                if (!bus.enemy_en)           state_d = IDLE;
                else if (gap_done && spawn_ok) state_d = FLY;
            end
            FLY:  if (retire) state_d = bus.enemy_en ? COOL : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cool_d = cool_q;
        x_d    = x_q;
        y_d    = y_q;
        en_d   = en_q;
        fire_d = 1'b0;
        case (state_q)
            IDLE: begin
                cool_d = '0;
                en_d   = 1'b0;
            end
            COOL: begin
                en_d = 1'b0;
                if (bus.enemy_en && tick) begin
                    if (gap_done) begin
                        // A blocked shot (spawn off-screen) restarts the gap.
                        cool_d = '0;
                        if (spawn_ok) begin
                            x_d    = clip_x;
                            y_d    = spawn_y[COORD_W-1:0];
                            en_d   = 1'b1;
                            fire_d = 1'b1;
                        end
                    end else begin
                        cool_d = cool_q + CCW'(1);
                    end
                end
            end
            FLY: begin
                if (retire) begin
                    en_d   = 1'b0;
                    cool_d = '0;
                end else if (tick) begin
                    y_d = step_y[COORD_W-1:0];
                end
            end
            default: begin
                en_d   = 1'b0;
                cool_d = '0;
            end
        endcase
    end

    assign bus.eb_x  = x_q;
    assign bus.eb_y  = y_q;
    assign bus.eb_en = en_q;
    assign bus.fire  = fire_q;

endmodule

// File: tb/tb_enemy_bullet_ctrl.sv
module tb_enemy_bullet_ctrl;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    enemy_bullet_ctrl_if bus();

    enemy_bullet_ctrl #(
        .MOVE_DIV (4),
        .STEP     (8),
        .FIRE_GAP (3),
        .MUZZLE_X (20),
        .MUZZLE_Y (40)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference movement tick: MOVE_DIV=4 -> 2-bit counter, tick on 3.
    logic [1:0] tcnt_m;
    logic       tick_m;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)          tcnt_m <= 2'd0;
        else if (!bus.pause) tcnt_m <= tcnt_m + 2'd1;
    end
    assign tick_m = !bus.pause && (tcnt_m == 2'd3);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Stop at the negedge just before the next tick edge.
    task automatic tick_pre();
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (tick_m) seen = 1'b1;
        end
        if (!seen) chk("tick_timeout", 32'd0, 32'd1);
    endtask

    task automatic next_tick();
        tick_pre();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_shot(input string tag, input int x, input int y);
        chk({tag, "_en"},   32'(bus.eb_en), 32'd1);
        chk({tag, "_fire"}, 32'(bus.fire),  32'd1);
        chk({tag, "_x"},    32'(bus.eb_x),  32'(x));
        chk({tag, "_y"},    32'(bus.eb_y),  32'(y));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;

        // 1. reset with random inputs
        rst_n        = 1'b0;
        bus.enemy_en = 1'($urandom);
        bus.e_x      = 10'($urandom);
        bus.e_y      = 10'($urandom);
        bus.pause    = 1'($urandom);
        bus.hit      = 1'($urandom);
        repeat (3) step();
        chk("rst_x",    32'(bus.eb_x),  32'd0);
        chk("rst_y",    32'(bus.eb_y),  32'd0);
        chk("rst_en",   32'(bus.eb_en), 32'd0);
        chk("rst_fire", 32'(bus.fire),  32'd0);
        bus.enemy_en = 1'b0;
        bus.pause    = 1'b0;
        bus.hit      = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            chk("idle_en",   32'(bus.eb_en), 32'd0);
            chk("idle_fire", 32'(bus.fire),  32'd0);
        end
        chk("idle_x", 32'(bus.eb_x), 32'd0);
        chk("idle_y", 32'(bus.eb_y), 32'd0);

        // 2. first shot after 3 ticks
        bus.enemy_en = 1'b1;
        bus.e_x      = 10'd100;
        bus.e_y      = 10'd50;
        step();
        next_tick();
        next_tick();
        chk("cool_en", 32'(bus.eb_en), 32'd0);
        next_tick();
        chk_shot("shot1", 120, 90);
        step();
        chk("shot1_fire_pulse", 32'(bus.fire), 32'd0);
        chk("shot1_en_hold",    32'(bus.eb_en), 32'd1);

        // 3. flight down to the bottom edge
        for (int k = 1; k <= 48; k++) begin
            next_tick();
            chk("fly_y",  32'(bus.eb_y),  32'(90 + 8 * k));
            chk("fly_en", 32'(bus.eb_en), 32'd1);
        end
        next_tick();
        chk("bottom_en", 32'(bus.eb_en), 32'd0);
        chk("bottom_y",  32'(bus.eb_y),  32'd474);
        next_tick();
        next_tick();
        chk("regap_en", 32'(bus.eb_en), 32'd0);
        next_tick();
        chk_shot("shot2", 120, 90);
        step();

        // 4. hit coincident with a tick at y=202, hit ignored in COOL
        for (int k = 0; k < 14; k++) next_tick();
        chk("prehit_y", 32'(bus.eb_y), 32'd202);
        tick_pre();
        bus.hit = 1'b1;
        step();
        chk("hit_en", 32'(bus.eb_en), 32'd0);
        chk("hit_y",  32'(bus.eb_y),  32'd202);
        next_tick();
        next_tick();
        chk("hit_cool_en", 32'(bus.eb_en), 32'd0);
        bus.hit = 1'b0;
        next_tick();
        chk_shot("shot3", 120, 90);
        bus.hit = 1'b1;
        step();
        bus.hit = 1'b0;
        chk("hit_notick_en", 32'(bus.eb_en), 32'd0);
        chk("hit_notick_y",  32'(bus.eb_y),  32'd90);

        // 5. spawn bounds
        bus.e_x = 10'd630;
        bus.e_y = 10'd100;
        repeat (3) next_tick();
        chk_shot("clip", 639, 140);
        bus.hit = 1'b1;
        step();
        bus.hit = 1'b0;
        bus.e_x = 10'd10;
        bus.e_y = 10'd445;
        repeat (3) next_tick();
        chk("noshot_en",   32'(bus.eb_en), 32'd0);
        chk("noshot_fire", 32'(bus.fire),  32'd0);
        chk("noshot_y",    32'(bus.eb_y),  32'd140);
        bus.e_y = 10'd400;
        next_tick();
        next_tick();
        chk("restart_en", 32'(bus.eb_en), 32'd0);
        next_tick();
        chk_shot("shot4", 30, 440);
        bus.enemy_en = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            next_tick();
            chk("orphan_y",  32'(bus.eb_y),  32'(440 + 8 * k));
            chk("orphan_en", 32'(bus.eb_en), 32'd1);
        end
        next_tick();
        chk("orphan_ret_en", 32'(bus.eb_en), 32'd0);
        chk("orphan_ret_y",  32'(bus.eb_y),  32'd472);
        repeat (4) next_tick();
        chk("dead_en", 32'(bus.eb_en), 32'd0);
        bus.enemy_en = 1'b1;
        bus.e_x      = 10'd100;
        bus.e_y      = 10'd50;
        step();
        next_tick();
        next_tick();
        chk("revive_en", 32'(bus.eb_en), 32'd0);
        next_tick();
        chk_shot("shot5", 120, 90);

        // 6. pause mid-flight, then async reset mid-flight
        bus.pause = 1'b1;
        repeat (20) step();
        chk("pause_y",  32'(bus.eb_y),  32'd90);
        chk("pause_en", 32'(bus.eb_en), 32'd1);
        bus.pause = 1'b0;
        next_tick();
        chk("unpause_y", 32'(bus.eb_y), 32'd98);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_en", 32'(bus.eb_en), 32'd0);
        chk("async_y",  32'(bus.eb_y),  32'd0);
        chk("async_x",  32'(bus.eb_x),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        next_tick();
        next_tick();
        chk("post_rst_en", 32'(bus.eb_en), 32'd0);
        next_tick();
        chk_shot("shot6", 120, 90);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
